// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states and
// small decode helpers used by both the controller and the lane aligner.
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'd19;
  localparam logic [5:0] OP_LH  = 6'd20;
  localparam logic [5:0] OP_LW  = 6'd21;
  localparam logic [5:0] OP_LBU = 6'd22;
  localparam logic [5:0] OP_LHU = 6'd23;
  localparam logic [5:0] OP_SB  = 6'd24;
  localparam logic [5:0] OP_SH  = 6'd25;
  localparam logic [5:0] OP_SW  = 6'd26;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  // Halves need an even address, words need a word-aligned address.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = addr[0];
      OP_LW, OP_SW:         bad = (addr != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide data-memory port with a req/ack handshake; the LSU is the master.
interface lsu_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rv2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  always_comb begin
    o_we    = 4'b0000;
    o_wdata = 32'h0;
    o_ldata = 32'h0;
    case (i_op)
      OP_SB: begin
        o_we    = 4'b0001 << i_addr;
        o_wdata = {4{i_rv2[7:0]}};
      end
      OP_SH: begin
        o_we    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_rv2[15:0]}};
      end
      OP_SW: begin
        o_we    = 4'b1111;
        o_wdata = i_rv2;
      end
      OP_LB:   o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      OP_LH:   o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      OP_LW:   o_ldata = w_shifted;
      OP_LBU:  o_ldata = {24'h0, w_shifted[7:0]};
      OP_LHU:  o_ldata = {16'h0, w_shifted[15:0]};
      default: o_ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one req/ack transaction per accepted op, with a
// one-cycle done/err pulse and a registered write-back result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [5:0]  i_op,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_rv2,
  input  logic [4:0]  i_rd,
  output logic        o_busy,
  lsu_if.master       mem,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data
);

  lsu_state_e  r_state;
  logic [5:0]  r_op;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic [31:0] r_tmo_cnt;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        r_done;
  logic        r_err;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic [5:0]  w_align_op;
  logic [1:0]  w_align_off;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  // In IDLE the aligner steers the incoming store; afterwards it decodes the load.
  assign w_align_op  = (r_state == IDLE) ? i_op : r_op;
  assign w_align_off = (r_state == IDLE) ? i_daddr[1:0] : r_off;

  lsu_align u_align (
    .i_op    (w_align_op),
    .i_addr  (w_align_off),
    .i_rv2   (i_rv2),
    .i_rdata (mem.mem_rdata),
    .o_we    (w_we),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 6'd0;
      r_off       <= 2'd0;
      r_rd        <= 5'd0;
      r_tmo_cnt   <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_we    <= 4'b0000;
      r_mem_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wb_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && is_mem_op(i_op)) begin
            r_op  <= i_op;
            r_off <= i_daddr[1:0];
            r_rd  <= i_rd;
            if (misaligned(i_op, i_daddr[1:0])) begin
              r_state   <= RESP;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_wb_rd   <= i_rd;
              r_wb_data <= 32'h0;
            end else begin
              r_state     <= REQ;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {i_daddr[31:2], 2'b00};
              r_mem_we    <= w_we;
              r_mem_wdata <= w_wdata;
              r_tmo_cnt   <= 32'd0;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            r_state   <= RESP;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_wb_rd   <= r_rd;
            r_wb_data <= is_load(r_op) ? w_ldata : 32'h0;
            r_wb_we   <= is_load(r_op) && (r_rd != 5'd0);
          end else if ((TIMEOUT != 0) && (r_tmo_cnt == 32'(TIMEOUT - 1))) begin
            r_state   <= RESP;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_wb_rd   <= r_rd;
            r_wb_data <= 32'h0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_wdata = r_mem_wdata;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_wb_we       = r_wb_we;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_data     = r_wb_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, self-checking bench for load_store_unit; cycle n is sampled 1ns after posedge n.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  op;
  logic [31:0] daddr;
  logic [31:0] rv2;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        err;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  lsu_if mem_bus ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .i_op      (op),
    .i_daddr   (daddr),
    .i_rv2     (rv2),
    .i_rd      (rd),
    .o_busy    (busy),
    .mem       (mem_bus.master),
    .o_done    (done),
    .o_err     (err),
    .o_wb_we   (wb_we),
    .o_wb_rd   (wb_rd),
    .o_wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns at cycle 1 of the transaction.
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    start = 1'b1;
    op    = o;
    daddr = a;
    rv2   = d;
    rd    = r;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_we !== 4'h0) begin errors++; $display("[TB] FAIL reset_we: got %h want 0", mem_bus.mem_we); end
    checks++; if ({done, err, wb_we} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 000", {done, err, wb_we}); end
    checks++; if (mem_bus.mem_addr !== 32'h0 || mem_bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: addr %h wdata %h want 0", mem_bus.mem_addr, mem_bus.mem_wdata); end
    checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb: rd %0d data %h want 0", wb_rd, wb_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_word();
    issue(6'd26, 32'h100, 32'hDEADBEEF, 5'd3);
    checks++; if (mem_bus.mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL sw_req: req %0b busy %0b want 1 1", mem_bus.mem_req, busy); end
    checks++; if (mem_bus.mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL sw_addr: got %h want 00000100", mem_bus.mem_addr); end
    checks++; if (mem_bus.mem_we !== 4'hF) begin errors++; $display("[TB] FAIL sw_we: got %h want f", mem_bus.mem_we); end
    checks++; if (mem_bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_wdata: got %h want deadbeef", mem_bus.mem_wdata); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if ({done, err, wb_we} !== 3'b100) begin errors++; $display("[TB] FAIL sw_done: done/err/wb_we %b want 100", {done, err, wb_we}); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_req_drop: got %0b want 0", mem_bus.mem_req); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sw_idle: done %0b busy %0b want 0 0", done, busy); end
  endtask

  task automatic test_load_byte_signed();
    issue(6'd19, 32'h203, 32'h0, 5'd5);
    checks++; if (mem_bus.mem_addr !== 32'h200 || mem_bus.mem_we !== 4'h0) begin errors++; $display("[TB] FAIL lb_bus: addr %h we %h want 00000200 0", mem_bus.mem_addr, mem_bus.mem_we); end
    tick();
    tick();
    checks++; if (done !== 1'b0 || mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_wait: done %0b req %0b want 0 1", done, mem_bus.mem_req); end
    mem_bus.mem_rdata = 32'h80123456;
    mem_bus.mem_ack   = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if ({done, err, wb_we} !== 3'b101) begin errors++; $display("[TB] FAIL lb_done: done/err/wb_we %b want 101", {done, err, wb_we}); end
    checks++; if (wb_data !== 32'hFFFFFF80 || wb_rd !== 5'd5) begin errors++; $display("[TB] FAIL lb_wb: data %h rd %0d want ffffff80 5", wb_data, wb_rd); end
    tick();
    checks++; if (wb_we !== 1'b0 || wb_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_hold: wb_we %0b data %h want 0 ffffff80", wb_we, wb_data); end
  endtask

  task automatic test_load_half();
    mem_bus.mem_rdata = 32'h80010000;
    issue(6'd23, 32'h202, 32'h0, 5'd7);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (wb_data !== 32'h00008001 || wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("[TB] FAIL lhu_wb: data %h we %0b rd %0d want 00008001 1 7", wb_data, wb_we, wb_rd); end
    tick();
    issue(6'd20, 32'h202, 32'h0, 5'd8);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (wb_data !== 32'hFFFF8001 || wb_we !== 1'b1) begin errors++; $display("[TB] FAIL lh_wb: data %h we %0b want ffff8001 1", wb_data, wb_we); end
    tick();
  endtask

  task automatic test_store_steering();
    issue(6'd24, 32'h101, 32'h000000AB, 5'd1);
    checks++; if (mem_bus.mem_we !== 4'b0010 || mem_bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("[TB] FAIL sb_lane: we %b wdata %h want 0010 abababab", mem_bus.mem_we, mem_bus.mem_wdata); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("[TB] FAIL sb_done: done %0b wb_we %0b want 1 0", done, wb_we); end
    tick();
    issue(6'd25, 32'h106, 32'h00001234, 5'd1);
    checks++; if (mem_bus.mem_we !== 4'b1100 || mem_bus.mem_wdata !== 32'h12341234 || mem_bus.mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL sh_lane: we %b wdata %h addr %h want 1100 12341234 00000104", mem_bus.mem_we, mem_bus.mem_wdata, mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    issue(6'd26, 32'h102, 32'h55555555, 5'd2);
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req: got %0b want 0", mem_bus.mem_req); end
    checks++; if ({done, err, wb_we} !== 3'b110) begin errors++; $display("[TB] FAIL mis_resp: done/err/wb_we %b want 110", {done, err, wb_we}); end
    tick();
    checks++; if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL mis_after: req %0b busy %0b err %0b want 0 0 0", mem_bus.mem_req, busy, err); end
  endtask

  task automatic test_timeout();
    int reqLow;
    reqLow = 0;
    issue(6'd21, 32'h300, 32'h0, 5'd4);
    for (int c = 1; c <= 16; c++) begin
      if (mem_bus.mem_req !== 1'b1 || done !== 1'b0) reqLow++;
      if (c < 16) tick();
    end
    checks++; if (reqLow !== 0) begin errors++; $display("[TB] FAIL tmo_req_window: %0d bad cycles in 1..16, want 0", reqLow); end
    tick();
    checks++; if ({done, err, wb_we} !== 3'b110 || mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL tmo_resp: done/err/wb_we %b req %0b want 110 0", {done, err, wb_we}, mem_bus.mem_req); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle: busy %0b want 0", busy); end
  endtask

  task automatic test_abort_recovery();
    issue(6'd21, 32'h400, 32'h0, 5'd6);
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre: req %0b want 1", mem_bus.mem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_drop: req %0b busy %0b want 0 0", mem_bus.mem_req, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_bus.mem_rdata = 32'h11223344;
    issue(6'd21, 32'h104, 32'h0, 5'd0);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if ({done, err, wb_we} !== 3'b100) begin errors++; $display("[TB] FAIL abort_rd0: done/err/wb_we %b want 100", {done, err, wb_we}); end
    tick();
  endtask

  task automatic test_ignored_inputs();
    mem_bus.mem_rdata = 32'h000000AA;
    issue(6'd21, 32'h500, 32'h0, 5'd9);
    start = 1'b1;
    op    = 6'd26;
    daddr = 32'h600;
    rv2   = 32'hFFFFFFFF;
    tick();
    checks++; if (mem_bus.mem_addr !== 32'h500 || mem_bus.mem_we !== 4'h0) begin errors++; $display("[TB] FAIL busy_start: addr %h we %h want 00000500 0", mem_bus.mem_addr, mem_bus.mem_we); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    start = 1'b0;
    checks++; if (wb_data !== 32'hAA || wb_rd !== 5'd9 || wb_we !== 1'b1) begin errors++; $display("[TB] FAIL busy_result: data %h rd %0d we %0b want 000000aa 9 1", wb_data, wb_rd, wb_we); end
    tick();
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (busy !== 1'b0 || mem_bus.mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: busy %0b req %0b done %0b want 0 0 0", busy, mem_bus.mem_req, done); end
    issue(6'd27, 32'h700, 32'h0, 5'd3);
    checks++; if (busy !== 1'b0 || mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bad_op: busy %0b req %0b want 0 0", busy, mem_bus.mem_req); end
  endtask

  task automatic test_back_to_back();
    mem_bus.mem_rdata = 32'hCAFEF00D;
    issue(6'd21, 32'h800, 32'h0, 5'd2);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || wb_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_first: done %0b data %h want 1 cafef00d", done, wb_data); end
    tick();
    issue(6'd24, 32'h903, 32'h00000077, 5'd0);
    checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 4'b1000 || mem_bus.mem_addr !== 32'h900) begin errors++; $display("[TB] FAIL b2b_second: req %0b we %b addr %h want 1 1000 00000900", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    rst_n             = 1'b0;
    start             = 1'b0;
    op                = 6'd0;
    daddr             = 32'h0;
    rv2               = 32'h0;
    rd                = 5'd0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_load_byte_signed();
    test_load_half();
    test_store_steering();
    test_misaligned();
    test_timeout();
    test_abort_recovery();
    test_ignored_inputs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
